// File: rtl/quad_decoder_if.sv
// Encoder pins, load/clear controls and position outputs of quad_decoder.
// The decoder side uses the slave modport; whoever drives the pins and consumes the position uses master.
interface quad_decoder_if #(
    parameter int WIDTH = 16,
    parameter int ERRW  = 8
);
    logic             a;
    logic             b;
    logic             z;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_err;
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             step;
    logic             err;
    logic [ERRW-1:0]  err_cnt;
    logic [WIDTH-1:0] idx_pos;
    logic             idx_valid;

    modport slave (
        input  a, b, z, load, load_val, clr_err,
        output cnt, dir, step, err, err_cnt, idx_pos, idx_valid
    );

    modport master (
        output a, b, z, load, load_val, clr_err,
        input  cnt, dir, step, err, err_cnt, idx_pos, idx_valid
    );
endinterface

// File: rtl/quad_decoder.sv
// Synchronous quadrature decoder: synchronise and filter A/B/Z, then decode phase changes
// into a wrapping position counter with skip-error counting and index clear/capture.
module quad_decoder #(
    parameter int WIDTH      = 16,
    parameter int FILTER     = 3,
    parameter int INDEX_MODE = 1,
    parameter int ERRW       = 8
) (
    input logic           clk,
    input logic           rst_n,
    quad_decoder_if.slave bus
);
    localparam int             FCW    = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [FCW-1:0] FC_MAX = FCW'(FILTER - 1);

    // Bit 0 = A, bit 1 = B, bit 2 = Z throughout.
    logic [2:0]          s1_q, s2_q, f_q, f_d, p_q;
    logic [2:0][FCW-1:0] fc_q, fc_d;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             step_q, step_d;
    logic             err_q, err_d;
    logic [ERRW-1:0]  errc_q, errc_d;
    logic [WIDTH-1:0] idx_pos_q, idx_pos_d;
    logic             idx_valid_q, idx_valid_d;
    logic [1:0]       ld_q, ld_d;   // last delta: 00 = none, 01 = +1, 11 = -1

    logic             a_chg, b_chg, single, dbl, fwd, z_rise, dec_upd;
    logic [WIDTH-1:0] step_delta, ld_ext, dbl_delta, dec_val;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            f_d[i]  = f_q[i];
            fc_d[i] = '0;
            if (s2_q[i] != f_q[i]) begin
                if (fc_q[i] == FC_MAX) f_d[i] = s2_q[i];
                else                   fc_d[i] = fc_q[i] + FCW'(1);
            end
        end
    end

    always_comb begin
        a_chg      = f_q[0] ^ p_q[0];
        b_chg      = f_q[1] ^ p_q[1];
        single     = a_chg ^ b_chg;
        dbl        = a_chg & b_chg;
        fwd        = f_q[1] ^ p_q[0];
        z_rise     = f_q[2] & ~p_q[2];
        step_delta = fwd ? WIDTH'(1) : '1;
        ld_ext     = (ld_q == 2'b01) ? WIDTH'(1) : ((ld_q == 2'b11) ? '1 : '0);
        dbl_delta  = {ld_ext[WIDTH-2:0], 1'b0};

        cnt_d       = cnt_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        err_d       = err_q;
        errc_d      = errc_q;
        idx_pos_d   = idx_pos_q;
        idx_valid_d = 1'b0;
        ld_d        = ld_q;
        dec_upd     = 1'b0;
        dec_val     = cnt_q;

        if (single) begin
            dec_val = cnt_q + step_delta;
            dec_upd = 1'b1;
            ld_d    = fwd ? 2'b01 : 2'b11;
            dir_d   = fwd;
        end else if (dbl) begin
            // A skipped step is assumed to continue in the last known direction.
            if (ld_q != 2'b00) begin
                dec_val = cnt_q + dbl_delta;
                dec_upd = 1'b1;
            end
            err_d = 1'b1;
            if (errc_q != '1) errc_d = errc_q + ERRW'(1);
        end

        if (bus.clr_err) begin
            err_d  = 1'b0;
            errc_d = '0;
        end

        if (bus.load) begin
            cnt_d = bus.load_val;
        end else if (INDEX_MODE == 1 && z_rise) begin
            cnt_d = '0;
        end else if (dec_upd) begin
            cnt_d  = dec_val;
            step_d = 1'b1;
        end

        if (INDEX_MODE == 1 && z_rise) idx_valid_d = 1'b1;
        if (INDEX_MODE == 2 && z_rise) begin
            idx_pos_d   = cnt_d;
            idx_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            f_q         <= '0;
            p_q         <= '0;
            fc_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
            errc_q      <= '0;
            idx_pos_q   <= '0;
            idx_valid_q <= 1'b0;
            ld_q        <= 2'b00;
        end else begin
            s1_q        <= {bus.z, bus.b, bus.a};
            s2_q        <= s1_q;
            f_q         <= f_d;
            p_q         <= f_q;
            fc_q        <= fc_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            err_q       <= err_d;
            errc_q      <= errc_d;
            idx_pos_q   <= idx_pos_d;
            idx_valid_q <= idx_valid_d;
            ld_q        <= ld_d;
        end
    end

    assign bus.cnt       = cnt_q;
    assign bus.dir       = dir_q;
    assign bus.step      = step_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = errc_q;
    assign bus.idx_pos   = idx_pos_q;
    assign bus.idx_valid = idx_valid_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: one instance in index-clear mode, one in index-capture mode,
// both driven by the same pin stimulus.
module tb_quad_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        a, b, z, load, clr_err;
    logic [15:0] load_val;
    int          total = 0;
    int          bad = 0;
    int          st1 = 0;
    int          iv1 = 0;
    int          iv2 = 0;
    int          base;
    int          ibase1, ibase2;

    always #5 clk = ~clk;

    quad_decoder_if #(.WIDTH(16), .ERRW(8)) bus1 ();
    quad_decoder_if #(.WIDTH(16), .ERRW(8)) bus2 ();

    assign bus1.a = a;  assign bus1.b = b;  assign bus1.z = z;
    assign bus1.load = load;  assign bus1.load_val = load_val;  assign bus1.clr_err = clr_err;
    assign bus2.a = a;  assign bus2.b = b;  assign bus2.z = z;
    assign bus2.load = load;  assign bus2.load_val = load_val;  assign bus2.clr_err = clr_err;

    quad_decoder #(.WIDTH(16), .FILTER(3), .INDEX_MODE(1), .ERRW(8)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
    );
    quad_decoder #(.WIDTH(16), .FILTER(3), .INDEX_MODE(2), .ERRW(8)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave)
    );

    // Pulse counters sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus1.step === 1'b1) st1++;
        if (bus1.idx_valid === 1'b1) iv1++;
        if (bus2.idx_valid === 1'b1) iv2++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ab(input logic na, input logic nb);
        @(negedge clk);
        a = na;
        b = nb;
        cyc(8);
    endtask

    task automatic do_load(input logic [15:0] v);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic pulse_a(input int n);
        @(negedge clk);
        a = ~a;
        cyc(n);
        a = ~a;
        cyc(10);
    endtask

    initial begin
        rst_n = 1'b0; a = 1'b0; b = 1'b0; z = 1'b0;
        load = 1'b0; load_val = '0; clr_err = 1'b0;
        cyc(3);
        check("rst_cnt", 32'(bus1.cnt), 0);
        check("rst_dir", 32'(bus1.dir), 0);
        check("rst_step", 32'(bus1.step), 0);
        check("rst_err", 32'(bus1.err), 0);
        check("rst_err_cnt", 32'(bus1.err_cnt), 0);
        check("rst_idx_valid", 32'(bus1.idx_valid), 0);
        check("rst_idx_pos", 32'(bus2.idx_pos), 0);
        rst_n = 1'b1;
        cyc(4);

        // Forward rotation 00->01->11->10->00, first step lands on edge 6.
        @(negedge clk);
        b = 1'b1;
        cyc(5);
        check("lat_step_e5", 32'(bus1.step), 0);
        check("lat_cnt_e5", 32'(bus1.cnt), 0);
        cyc(1);
        check("lat_step_e6", 32'(bus1.step), 1);
        check("lat_cnt_e6", 32'(bus1.cnt), 1);
        cyc(2);
        set_ab(1, 1);
        set_ab(1, 0);
        set_ab(0, 0);
        check("fwd_cnt", 32'(bus1.cnt), 4);
        check("fwd_dir", 32'(bus1.dir), 1);
        check("fwd_steps", st1, 4);
        check("fwd_cnt_m2", 32'(bus2.cnt), 4);

        // Backward through zero, then forward wrap from 0xFFFF.
        do_load(16'h0000);
        check("load0", 32'(bus1.cnt), 0);
        set_ab(1, 0);
        set_ab(1, 1);
        check("bwd_cnt", 32'(bus1.cnt), 32'hFFFE);
        check("bwd_dir", 32'(bus1.dir), 0);
        do_load(16'hFFFF);
        check("load_ffff", 32'(bus1.cnt), 32'hFFFF);
        set_ab(1, 0);
        check("wrap_cnt", 32'(bus1.cnt), 0);
        check("wrap_dir", 32'(bus1.dir), 1);

        // Glitch rejection on A (currently A=1, B=0).
        base = st1;
        pulse_a(2);
        check("glitch2_cnt", 32'(bus1.cnt), 0);
        check("glitch2_steps", st1, base);
        check("glitch2_err", 32'(bus1.err), 0);
        pulse_a(3);
        check("glitch3_cnt", 32'(bus1.cnt), 0);
        check("glitch3_steps", st1, base + 2);
        check("glitch3_dir", 32'(bus1.dir), 0);

        // Three forward steps, then a double change 11->00.
        do_load(16'h0000);
        set_ab(0, 0);
        set_ab(0, 1);
        set_ab(1, 1);
        check("pre_dbl_cnt", 32'(bus1.cnt), 3);
        base = st1;
        set_ab(0, 0);
        check("dbl_cnt", 32'(bus1.cnt), 5);
        check("dbl_err", 32'(bus1.err), 1);
        check("dbl_err_cnt", 32'(bus1.err_cnt), 1);
        check("dbl_steps", st1, base + 1);
        check("dbl_dir", 32'(bus1.dir), 1);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err", 32'(bus1.err), 0);
        check("clr_err_cnt", 32'(bus1.err_cnt), 0);
        check("clr_cnt_kept", 32'(bus1.cnt), 5);

        // Index with cnt = 37.
        do_load(16'd37);
        ibase1 = iv1;
        ibase2 = iv2;
        @(negedge clk);
        z = 1'b1;
        cyc(8);
        check("idx1_cnt", 32'(bus1.cnt), 0);
        check("idx1_pulse", iv1, ibase1 + 1);
        check("idx2_cnt", 32'(bus2.cnt), 37);
        check("idx2_pos", 32'(bus2.idx_pos), 37);
        check("idx2_pulse", iv2, ibase2 + 1);
        @(negedge clk);
        z = 1'b0;
        cyc(8);
        check("idx_fall_1", iv1, ibase1 + 1);
        check("idx_fall_2", iv2, ibase2 + 1);

        // Index rising together with a forward step.
        do_load(16'd10);
        @(negedge clk);
        z = 1'b1;
        b = 1'b1;
        cyc(8);
        check("idxstep1_cnt", 32'(bus1.cnt), 0);
        check("idxstep1_dir", 32'(bus1.dir), 1);
        check("idxstep2_cnt", 32'(bus2.cnt), 11);
        check("idxstep2_pos", 32'(bus2.idx_pos), 11);
        @(negedge clk);
        z = 1'b0;
        cyc(8);

        // Reset mid-rotation with cnt = 100 and err = 1.
        do_load(16'd98);
        set_ab(1, 0);
        check("pre_rst_cnt", 32'(bus1.cnt), 100);
        check("pre_rst_err", 32'(bus1.err), 1);
        @(negedge clk);
        a = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("rst_sync_cnt", 32'(bus1.cnt), 100);
        check("rst_sync_err", 32'(bus1.err), 1);
        @(negedge clk);
        check("midrst_cnt", 32'(bus1.cnt), 0);
        check("midrst_err", 32'(bus1.err), 0);
        check("midrst_err_cnt", 32'(bus1.err_cnt), 0);
        check("midrst_dir", 32'(bus1.dir), 0);
        check("midrst_step", 32'(bus1.step), 0);
        check("midrst_cnt_m2", 32'(bus2.cnt), 0);
        check("midrst_pos_m2", 32'(bus2.idx_pos), 0);
        rst_n = 1'b1;
        base = st1;
        cyc(12);
        check("post_rst_cnt", 32'(bus1.cnt), 0);
        check("post_rst_steps", st1, base);

        // Double change with no prior valid step: err only, no count.
        set_ab(1, 1);
        check("dbl0_cnt", 32'(bus1.cnt), 0);
        check("dbl0_err", 32'(bus1.err), 1);
        check("dbl0_err_cnt", 32'(bus1.err_cnt), 1);
        check("dbl0_steps", st1, base);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
